unidade_de_controle_multiciclo: RTL and testbench

//   Multi-cycle control unit: Moore FSM that sequences each instruction through

---
 rtl/unidade_de_controle_multiciclo.sv | 265 ++++++++++++++++++++++++++
 tb/tb_unidade_de_controle_multiciclo.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/unidade_de_controle_multiciclo.sv
// Multi-cycle MIPS control unit: Moore FSM sequencing FETCH/DECODE/EXEC/MEM/WB with memory handshake and retire counter.
// Define UC_ILLEGAL_TRAP_EN to trap on illegal opcodes (adds the trap port); otherwise illegal opcodes retire as NOPs.
module unidade_de_controle_multiciclo #(
  parameter int unsigned OP_W    = 6,
  parameter int unsigned ALUOP_W = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [OP_W-1:0]    instrucao,
  input  logic               mem_ready,
  output logic               pcWrite,
  output logic               pcWriteCond,
  output logic               branchNe,
  output logic               iorD,
  output logic               irWrite,
  output logic               memRead,
  output logic               memWrite,
  output logic               memtoReg,
  output logic               regDst,
  output logic               regWrite,
  output logic               aluSrcA,
  output logic [1:0]         aluSrcB,
  output logic [ALUOP_W-1:0] aluOp,
  output logic [1:0]         pcSource,
  output logic [CNT_W-1:0]   instr_count
`ifdef UC_ILLEGAL_TRAP_EN
  ,
  output logic               trap
`endif
);

  localparam logic [OP_W-1:0] OP_R   = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_I   = OP_W'(6'b000001);
  localparam logic [OP_W-1:0] OP_LW  = OP_W'(6'b100010);
  localparam logic [OP_W-1:0] OP_LWI = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW  = OP_W'(6'b101010);
  localparam logic [OP_W-1:0] OP_BEQ = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_BNE = OP_W'(6'b000110);
  localparam logic [OP_W-1:0] OP_J   = OP_W'(6'b010000);

  localparam logic [ALUOP_W-1:0] ALU_00 = ALUOP_W'(2'b00);
  localparam logic [ALUOP_W-1:0] ALU_01 = ALUOP_W'(2'b01);
  localparam logic [ALUOP_W-1:0] ALU_10 = ALUOP_W'(2'b10);
  localparam logic [ALUOP_W-1:0] ALU_11 = ALUOP_W'(2'b11);

  typedef enum logic [3:0] {
    S_RST, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ADDR, S_MEM_RD,
    S_MEM_WR, S_WB_MEM, S_WB_ALU, S_BRANCH, S_JUMP, S_TRAP
  } state_t;

  state_t              r_state, w_next;
  logic [OP_W-1:0]     r_op, w_op;
  logic                w_retire;
  logic [CNT_W-1:0]    r_cnt;

  logic                r_pc_write, w_pc_write;
  logic                r_pc_write_cond, w_pc_write_cond;
  logic                r_branch_ne, w_branch_ne;
  logic                r_iord, w_iord;
  logic                r_mem_read, w_mem_read;
  logic                r_mem_write, w_mem_write;
  logic                r_memto_reg, w_memto_reg;
  logic                r_reg_dst, w_reg_dst;
  logic                r_reg_write, w_reg_write;
  logic                r_alu_src_a, w_alu_src_a;
  logic [1:0]          r_alu_src_b, w_alu_src_b;
  logic [ALUOP_W-1:0]  r_alu_op, w_alu_op;
  logic [1:0]          r_pc_source, w_pc_source;
  logic                w_fetch_done;
`ifdef UC_ILLEGAL_TRAP_EN
  logic                r_trap, w_trap;
`endif

  // Next-state transitions, then Moore decode of the state being entered so outputs can be registered
  always_comb begin
    w_next          = r_state;
    w_op            = r_op;
    w_retire        = 1'b0;
    w_pc_write      = 1'b0;
    w_pc_write_cond = 1'b0;
    w_branch_ne     = 1'b0;
    w_iord          = 1'b0;
    w_mem_read      = 1'b0;
    w_mem_write     = 1'b0;
    w_memto_reg     = 1'b0;
    w_reg_dst       = 1'b0;
    w_reg_write     = 1'b0;
    w_alu_src_a     = 1'b0;
    w_alu_src_b     = 2'b00;
    w_alu_op        = ALU_00;
    w_pc_source     = 2'b00;
`ifdef UC_ILLEGAL_TRAP_EN
    w_trap          = 1'b0;
`endif

    case (r_state)
      S_RST:   w_next = S_FETCH;
      S_FETCH: if (mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        w_op = instrucao;
        case (instrucao)
          OP_R:                 w_next = S_EXEC_R;
          OP_I:                 w_next = S_EXEC_I;
          OP_LW, OP_LWI, OP_SW: w_next = S_ADDR;
          OP_BEQ, OP_BNE:       w_next = S_BRANCH;
          OP_J:                 w_next = S_JUMP;
          default: begin
`ifdef UC_ILLEGAL_TRAP_EN
            w_next = S_TRAP;
`else
            w_next   = S_FETCH;
            w_retire = 1'b1;
`endif
          end
        endcase
      end
      S_EXEC_R, S_EXEC_I: w_next = S_WB_ALU;
      S_ADDR: begin
        case (r_op)
          OP_LWI:  w_next = S_WB_ALU;
          OP_LW:   w_next = S_MEM_RD;
          default: w_next = S_MEM_WR;
        endcase
      end
      S_MEM_RD: if (mem_ready) w_next = S_WB_MEM;
      S_MEM_WR: begin
        if (mem_ready) begin
          w_next   = S_FETCH;
          w_retire = 1'b1;
        end
      end
      S_WB_MEM, S_WB_ALU, S_BRANCH, S_JUMP: begin
        w_next   = S_FETCH;
        w_retire = 1'b1;
      end
      S_TRAP:  w_next = S_TRAP;
      default: w_next = S_RST;
    endcase

    case (w_next)
      S_FETCH: begin
        w_mem_read  = 1'b1;
        w_alu_src_b = 2'b01;
      end
      S_DECODE: w_alu_src_b = 2'b11;
      S_EXEC_R: begin
        w_alu_src_a = 1'b1;
        w_alu_op    = ALU_10;
      end
      S_EXEC_I: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
        w_alu_op    = ALU_10;
      end
      S_ADDR: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
        if (w_op == OP_LWI)     w_alu_op = ALU_01;
        else if (w_op == OP_LW) w_alu_op = ALU_11;
        else                    w_alu_op = ALU_00;
      end
      S_MEM_RD: begin
        w_mem_read = 1'b1;
        w_iord     = 1'b1;
      end
      S_MEM_WR: begin
        w_mem_write = 1'b1;
        w_iord      = 1'b1;
      end
      S_WB_MEM: begin
        w_reg_write = 1'b1;
        w_memto_reg = 1'b1;
      end
      S_WB_ALU: begin
        w_reg_write = 1'b1;
        // lwi writes rt; R-type and I-type arithmetic write rd
        w_reg_dst   = (r_state != S_ADDR);
      end
      S_BRANCH: begin
        w_alu_src_a     = 1'b1;
        w_alu_op        = ALU_01;
        w_pc_write_cond = 1'b1;
        w_pc_source     = 2'b01;
        w_branch_ne     = (w_op == OP_BNE);
      end
      S_JUMP: begin
        w_pc_write  = 1'b1;
        w_pc_source = 2'b10;
      end
`ifdef UC_ILLEGAL_TRAP_EN
      S_TRAP: w_trap = 1'b1;
`endif
      default: ;
    endcase
  end

  // State, latched opcode, retire counter and registered Moore outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_RST;
      r_op            <= '0;
      r_cnt           <= '0;
      r_pc_write      <= 1'b0;
      r_pc_write_cond <= 1'b0;
      r_branch_ne     <= 1'b0;
      r_iord          <= 1'b0;
      r_mem_read      <= 1'b0;
      r_mem_write     <= 1'b0;
      r_memto_reg     <= 1'b0;
      r_reg_dst       <= 1'b0;
      r_reg_write     <= 1'b0;
      r_alu_src_a     <= 1'b0;
      r_alu_src_b     <= 2'b00;
      r_alu_op        <= ALU_00;
      r_pc_source     <= 2'b00;
`ifdef UC_ILLEGAL_TRAP_EN
      r_trap          <= 1'b0;
`endif
    end else begin
      r_state         <= w_next;
      r_op            <= w_op;
      r_cnt           <= r_cnt + CNT_W'(w_retire);
      r_pc_write      <= w_pc_write;
      r_pc_write_cond <= w_pc_write_cond;
      r_branch_ne     <= w_branch_ne;
      r_iord          <= w_iord;
      r_mem_read      <= w_mem_read;
      r_mem_write     <= w_mem_write;
      r_memto_reg     <= w_memto_reg;
      r_reg_dst       <= w_reg_dst;
      r_reg_write     <= w_reg_write;
      r_alu_src_a     <= w_alu_src_a;
      r_alu_src_b     <= w_alu_src_b;
      r_alu_op        <= w_alu_op;
      r_pc_source     <= w_pc_source;
`ifdef UC_ILLEGAL_TRAP_EN
      r_trap          <= w_trap;
`endif
    end
  end

  // IR and PC load in FETCH follow the memory handshake within the same cycle
  assign w_fetch_done = (r_state == S_FETCH) && mem_ready;

  assign pcWrite     = r_pc_write | w_fetch_done;
  assign irWrite     = w_fetch_done;
  assign pcWriteCond = r_pc_write_cond;
  assign branchNe    = r_branch_ne;
  assign iorD        = r_iord;
  assign memRead     = r_mem_read;
  assign memWrite    = r_mem_write;
  assign memtoReg    = r_memto_reg;
  assign regDst      = r_reg_dst;
  assign regWrite    = r_reg_write;
  assign aluSrcA     = r_alu_src_a;
  assign aluSrcB     = r_alu_src_b;
  assign aluOp       = r_alu_op;
  assign pcSource    = r_pc_source;
  assign instr_count = r_cnt;
`ifdef UC_ILLEGAL_TRAP_EN
  assign trap        = r_trap;
`endif

endmodule

// File: tb/tb_unidade_de_controle_multiciclo.sv
// Table-driven bench for the multi-cycle control unit, plus reset, illegal-opcode and counter-wrap sequences.
module tb_unidade_de_controle_multiciclo;

  localparam int unsigned CNT_W = 4;
  localparam logic [5:0]  J     = 6'h3F;

  logic             clk, rst_n, mem_ready;
  logic [5:0]       instrucao;
  logic             pcWrite, pcWriteCond, branchNe, iorD, irWrite, memRead, memWrite;
  logic             memtoReg, regDst, regWrite, aluSrcA;
  logic [1:0]       aluSrcB, aluOp, pcSource;
  logic [CNT_W-1:0] instr_count;
  logic [16:0]      w_ctl;
`ifdef UC_ILLEGAL_TRAP_EN
  logic             trap;
`endif

  int n_checks = 0;
  int n_err    = 0;

  unidade_de_controle_multiciclo #(.OP_W(6), .ALUOP_W(2), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .instrucao(instrucao), .mem_ready(mem_ready),
    .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .branchNe(branchNe), .iorD(iorD),
    .irWrite(irWrite), .memRead(memRead), .memWrite(memWrite), .memtoReg(memtoReg),
    .regDst(regDst), .regWrite(regWrite), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB),
    .aluOp(aluOp), .pcSource(pcSource), .instr_count(instr_count)
`ifdef UC_ILLEGAL_TRAP_EN
    , .trap(trap)
`endif
  );

  assign w_ctl = {pcWrite, pcWriteCond, branchNe, iorD, irWrite, memRead, memWrite,
                  memtoReg, regDst, regWrite, aluSrcA, aluSrcB, aluOp, pcSource};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  function automatic logic [16:0] mk(input logic pw, pwc, bne, iord, irw, mr, mw, m2r, rdst, rw, asa,
                                     input logic [1:0] asb, aop, psrc);
    return {pw, pwc, bne, iord, irw, mr, mw, m2r, rdst, rw, asa, asb, aop, psrc};
  endfunction

  function automatic logic [16:0] c_fetch(input logic m);
    return mk(m,0,0,0,m,1,0,0,0,0,0, 2'b01, 2'b00, 2'b00);
  endfunction
  function automatic logic [16:0] c_dec();
    return mk(0,0,0,0,0,0,0,0,0,0,0, 2'b11, 2'b00, 2'b00);
  endfunction
  function automatic logic [16:0] c_exr();
    return mk(0,0,0,0,0,0,0,0,0,0,1, 2'b00, 2'b10, 2'b00);
  endfunction
  function automatic logic [16:0] c_exi();
    return mk(0,0,0,0,0,0,0,0,0,0,1, 2'b10, 2'b10, 2'b00);
  endfunction
  function automatic logic [16:0] c_addr(input logic [1:0] a);
    return mk(0,0,0,0,0,0,0,0,0,0,1, 2'b10, a, 2'b00);
  endfunction
  function automatic logic [16:0] c_mrd();
    return mk(0,0,0,1,0,1,0,0,0,0,0, 2'b00, 2'b00, 2'b00);
  endfunction
  function automatic logic [16:0] c_mwr();
    return mk(0,0,0,1,0,0,1,0,0,0,0, 2'b00, 2'b00, 2'b00);
  endfunction
  function automatic logic [16:0] c_wbm();
    return mk(0,0,0,0,0,0,0,1,0,1,0, 2'b00, 2'b00, 2'b00);
  endfunction
  function automatic logic [16:0] c_wba(input logic d);
    return mk(0,0,0,0,0,0,0,0,d,1,0, 2'b00, 2'b00, 2'b00);
  endfunction
  function automatic logic [16:0] c_br(input logic n);
    return mk(0,1,n,0,0,0,0,0,0,0,1, 2'b00, 2'b01, 2'b01);
  endfunction
  function automatic logic [16:0] c_jmp();
    return mk(1,0,0,0,0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b10);
  endfunction

  typedef struct {
    logic             rst;
    logic [5:0]       op;
    logic             mr;
    logic [16:0]      ctl;
    logic [CNT_W-1:0] cnt;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic r, input logic [5:0] op, input logic mr,
                     input logic [16:0] ctl, input logic [CNT_W-1:0] cnt);
    vec_t v;
    v.rst = r; v.op = op; v.mr = mr; v.ctl = ctl; v.cnt = cnt;
    tv.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n     = 1'b0;
    instrucao = J;
    mem_ready = 1'b0;

    // one row per cycle: inputs for the cycle and the Moore outputs expected during it
    add(0, J, 0, '0, 0);
    add(1, J, 0, '0, 0);
    add(1, J,     1, c_fetch(1), 0); add(1, 6'h00, 0, c_dec(), 0);
    add(1, J,     0, c_exr(),    0); add(1, J,     1, c_wba(1), 0);
    add(1, J,     0, c_fetch(0), 1); add(1, J,     1, c_fetch(1), 1);
    add(1, 6'h01, 1, c_dec(),    1); add(1, J,     0, c_exi(),  1);
    add(1, J,     0, c_wba(1),   1);
    add(1, J,     1, c_fetch(1), 2); add(1, 6'h23, 0, c_dec(),  2);
    add(1, J,     1, c_addr(2'b01), 2); add(1, J,  0, c_wba(0), 2);
    add(1, J,     1, c_fetch(1), 3); add(1, 6'h22, 1, c_dec(),  3);
    add(1, J,     1, c_addr(2'b11), 3);
    add(1, J,     0, c_mrd(),    3); add(1, J,     0, c_mrd(),  3);
    add(1, J,     0, c_mrd(),    3); add(1, J,     1, c_mrd(),  3);
    add(1, J,     0, c_wbm(),    3);
    add(1, J,     1, c_fetch(1), 4); add(1, 6'h2A, 1, c_dec(),  4);
    add(1, J,     0, c_addr(2'b00), 4);
    add(1, J,     0, c_mwr(),    4); add(1, J,     1, c_mwr(),  4);
    add(1, J,     1, c_fetch(1), 5); add(1, 6'h06, 0, c_dec(),  5);
    add(1, J,     1, c_br(1),    5);
    add(1, J,     1, c_fetch(1), 6); add(1, 6'h04, 0, c_dec(),  6);
    add(1, J,     0, c_br(0),    6);
    add(1, J,     1, c_fetch(1), 7); add(1, 6'h10, 0, c_dec(),  7);
    add(1, J,     0, c_jmp(),    7);
    add(1, J,     0, c_fetch(0), 8);

    @(negedge clk);
    for (int i = 0; i < tv.size(); i++) begin
      rst_n     = tv[i].rst;
      instrucao = tv[i].op;
      mem_ready = tv[i].mr;
      #1;
      chk($sformatf("vec%0d ctl", i), 32'(w_ctl), 32'(tv[i].ctl));
      chk($sformatf("vec%0d cnt", i), 32'(instr_count), 32'(tv[i].cnt));
      cyc();
    end

    // lw stalled in MEM_RD, then reset held for 3 cycles
    mem_ready = 1'b1; instrucao = J; cyc();
    instrucao = 6'h22; cyc();
    instrucao = J; cyc();
    mem_ready = 1'b0; #1;
    chk("memrd_enter ctl", 32'(w_ctl), 32'(c_mrd()));
    cyc(); #1;
    chk("memrd_hold ctl", 32'(w_ctl), 32'(c_mrd()));
    rst_n = 1'b0; mem_ready = 1'b1; #1;
    chk("rst_async ctl", 32'(w_ctl), 32'd0);
    chk("rst_async cnt", 32'(instr_count), 32'd0);
    for (int k = 0; k < 3; k++) begin
      cyc(); #1;
      chk($sformatf("rst_hold%0d ctl", k), 32'(w_ctl), 32'd0);
      chk($sformatf("rst_hold%0d cnt", k), 32'(instr_count), 32'd0);
`ifdef UC_ILLEGAL_TRAP_EN
      chk($sformatf("rst_hold%0d trap", k), 32'(trap), 32'd0);
`endif
    end
    rst_n = 1'b1; #1;
    chk("post_rst S_RST ctl", 32'(w_ctl), 32'd0);
    cyc(); #1;
    chk("post_rst fetch ctl", 32'(w_ctl), 32'(c_fetch(1)));
    chk("post_rst fetch cnt", 32'(instr_count), 32'd0);

    // illegal opcode 111111
    cyc();
    instrucao = 6'h3F; mem_ready = 1'b0; #1;
    chk("illegal decode ctl", 32'(w_ctl), 32'(c_dec()));
    cyc();
`ifdef UC_ILLEGAL_TRAP_EN
    for (int k = 0; k < 3; k++) begin
      mem_ready = 1'b1; instrucao = 6'h00; #1;
      chk($sformatf("trap%0d flag", k), 32'(trap), 32'd1);
      chk($sformatf("trap%0d ctl", k), 32'(w_ctl), 32'd0);
      chk($sformatf("trap%0d cnt", k), 32'(instr_count), 32'd0);
      cyc();
    end
`else
    #1;
    chk("nop fetch ctl", 32'(w_ctl), 32'(c_fetch(0)));
    chk("nop retire cnt", 32'(instr_count), 32'd1);
`endif

    // counter wrap over 16 jumps
    rst_n = 1'b0; #1;
    chk("wrap rst cnt", 32'(instr_count), 32'd0);
    cyc();
    rst_n = 1'b1; cyc();
    for (int j = 0; j < 16; j++) begin
      mem_ready = 1'b1; instrucao = J; cyc();
      instrucao = 6'h10; cyc();
      instrucao = J; #1;
      chk($sformatf("jump%0d ctl", j), 32'(w_ctl), 32'(c_jmp()));
      chk($sformatf("jump%0d cnt", j), 32'(instr_count), 32'(j));
      cyc();
    end
    #1;
    chk("wrap cnt", 32'(instr_count), 32'd0);
    chk("wrap fetch ctl", 32'(w_ctl), 32'(c_fetch(1)));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
